block_scheduler: RTL and testbench

BLOCK_SCHEDULER -- requirements
Module: block_scheduler

---
 rtl/gpu_pkg.sv | 18 +
 rtl/block_scheduler_launch_fifo.sv | 50 +++++
 rtl/block_scheduler.sv | 159 +++++++++++++++
 tb/tb_block_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU front-end definitions: scheduler state encoding and width helpers.
package gpu_pkg;

  localparam int BLOCK_ID_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DISPATCH,
    S_DRAIN
  } sched_state_e;

  // Width of a per-core thread count able to hold the value threads_per_block itself.
  function automatic int thread_cnt_w(input int threads_per_block);
    return $clog2(threads_per_block) + 1;
  endfunction

endpackage

// File: rtl/block_scheduler_launch_fifo.sv
// Kernel launch queue: power-of-two depth FIFO with occupancy count.
module launch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int QW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == QW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: storage carries no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + QW'(do_push) - QW'(do_pop);
    end
  end

endmodule

// File: rtl/block_scheduler.sv
// Queues kernel launches and splits each into thread blocks dispatched to idle cores.
// Optional kernel cycle counter enabled by defining BLOCK_SCHEDULER_PERF_EN.
module block_scheduler
  import gpu_pkg::*;
#(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_COUNT_BITS = 8,
  parameter int LAUNCH_DEPTH      = 4
) (
  input  logic                                                     clk,
  input  logic                                                     reset,
  input  logic                                                     launch_valid,
  output logic                                                     launch_ready,
  input  logic [THREAD_COUNT_BITS-1:0]                             launch_thread_count,
  input  logic [NUM_CORES-1:0]                                     core_done,
  output logic [NUM_CORES-1:0]                                     core_start,
  output logic [NUM_CORES-1:0]                                     core_reset,
  output logic [NUM_CORES-1:0][BLOCK_ID_W-1:0]                     core_block_id,
  output logic [NUM_CORES-1:0][thread_cnt_w(THREADS_PER_BLOCK)-1:0] core_thread_count,
  output logic                                                     kernel_done,
  output logic                                                     busy,
  output logic [$clog2(LAUNCH_DEPTH):0]                            queue_count
`ifdef BLOCK_SCHEDULER_PERF_EN
  ,
  output logic [31:0]                                              kernel_cycles
`endif
);

  localparam int TCB = THREAD_COUNT_BITS;
  localparam int TCW = thread_cnt_w(THREADS_PER_BLOCK);

  sched_state_e           state_q, state_d;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [TCB-1:0]         fifo_dout;
  logic [TCB-1:0]         total_q, dispatched_q, done_q;
  logic [TCW-1:0]         last_tc_q;
  logic                   empty_done_q;
  logic [TCB:0]           tc_round;
  logic [TCB-1:0]         total_d;
  logic [TCB-1:0]         tc_rem;
  logic [TCW-1:0]         last_tc_d;
  logic [NUM_CORES-1:0]   done_acc, idle, pick_oh;
  logic [TCB-1:0]         done_inc;
  logic                   assign_en;

  launch_fifo #(
    .WIDTH (TCB),
    .DEPTH (LAUNCH_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (launch_valid),
    .push_data (launch_thread_count),
    .pop       (state_q == S_LOAD),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (queue_count)
  );

  assign launch_ready = !fifo_full;
  assign busy         = (state_q != S_IDLE) || (queue_count != '0);

  // Block count rounds up; the last block carries the remainder, or a full block when it divides evenly.
  assign tc_round  = {1'b0, fifo_dout} + (TCB+1)'(THREADS_PER_BLOCK - 1);
  assign total_d   = TCB'(tc_round / (TCB+1)'(THREADS_PER_BLOCK));
  assign tc_rem    = fifo_dout % TCB'(THREADS_PER_BLOCK);
  assign last_tc_d = (tc_rem == '0) ? TCW'(THREADS_PER_BLOCK) : TCW'(tc_rem);

  // Cores count as busy from the reset pulse until their accepted done drops core_start.
  assign done_acc = core_done & core_start;
  assign idle     = ~(core_start | core_reset);
  assign pick_oh  = idle & (~idle + NUM_CORES'(1));

  always_comb begin
    done_inc = '0;
    for (int i = 0; i < NUM_CORES; i++) done_inc = done_inc + TCB'(done_acc[i]);
  end

  // NOTE: every combinational output gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d     = state_q;
    assign_en   = 1'b0;
    kernel_done = empty_done_q;
    unique case (state_q)
      S_IDLE:     if (!fifo_empty) state_d = S_LOAD;
      S_LOAD:     state_d = (fifo_dout == '0) ? S_IDLE : S_DISPATCH;
      S_DISPATCH: begin
        if (dispatched_q == total_q) state_d = S_DRAIN;
        else assign_en = |idle;
      end
      S_DRAIN: begin
        if (done_q == total_q) begin
          state_d     = S_IDLE;
          kernel_done = 1'b1;
        end
      end
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_q           <= '0;
      dispatched_q      <= '0;
      done_q            <= '0;
      last_tc_q         <= '0;
      empty_done_q      <= 1'b0;
      core_start        <= '0;
      core_reset        <= '0;
      core_block_id     <= '0;
      core_thread_count <= '0;
    end else begin
      empty_done_q <= (state_q == S_LOAD) && (fifo_dout == '0);
      if (state_q == S_LOAD) begin
        total_q      <= total_d;
        last_tc_q    <= last_tc_d;
        dispatched_q <= '0;
        done_q       <= '0;
      end else begin
        done_q <= done_q + done_inc;
        if (assign_en) dispatched_q <= dispatched_q + TCB'(1);
      end
      core_start <= core_reset | (core_start & ~done_acc);
      core_reset <= assign_en ? pick_oh : '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (assign_en && pick_oh[i]) begin
          core_block_id[i]     <= BLOCK_ID_W'(dispatched_q);
          core_thread_count[i] <= (dispatched_q == total_q - TCB'(1)) ? last_tc_q
                                                                      : TCW'(THREADS_PER_BLOCK);
        end
      end
    end
  end

`ifdef BLOCK_SCHEDULER_PERF_EN
  logic [31:0] cyc_q;

  // cyc_q counts cycles since LOAD, excluding the current one; the latch adds it back in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q         <= '0;
      kernel_cycles <= '0;
    end else begin
      if (state_q == S_LOAD)                          cyc_q <= 32'd1;
      else if (state_q != S_IDLE && cyc_q != '1)      cyc_q <= cyc_q + 32'd1;
      if (kernel_done) kernel_cycles <= (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_block_scheduler.sv
// Directed self-checking bench for block_scheduler with default parameters (2 cores, 4 threads/block).
module tb_block_scheduler;

  logic            clk = 1'b0;
  logic            reset;
  logic            launch_valid;
  logic            launch_ready;
  logic [7:0]      launch_thread_count;
  logic [1:0]      core_done;
  logic [1:0]      core_start;
  logic [1:0]      core_reset;
  logic [1:0][7:0] core_block_id;
  logic [1:0][2:0] core_thread_count;
  logic            kernel_done;
  logic            busy;
  logic [2:0]      queue_count;
`ifdef BLOCK_SCHEDULER_PERF_EN
  logic [31:0]     kernel_cycles;
`endif

  int n_checks   = 0;
  int n_pass     = 0;
  int kd_seen    = 0;
  int touch_seen = 0;
  int kd0;
  int touch0;

  always #5 clk = ~clk;

  block_scheduler #(
    .NUM_CORES         (2),
    .THREADS_PER_BLOCK (4),
    .THREAD_COUNT_BITS (8),
    .LAUNCH_DEPTH      (4)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .launch_valid        (launch_valid),
    .launch_ready        (launch_ready),
    .launch_thread_count (launch_thread_count),
    .core_done           (core_done),
    .core_start          (core_start),
    .core_reset          (core_reset),
    .core_block_id       (core_block_id),
    .core_thread_count   (core_thread_count),
    .kernel_done         (kernel_done),
    .busy                (busy),
    .queue_count         (queue_count)
`ifdef BLOCK_SCHEDULER_PERF_EN
    ,
    .kernel_cycles       (kernel_cycles)
`endif
  );

  // Event counters sampled on the active edge; read back only at negedges.
  always @(posedge clk) begin
    if (kernel_done === 1'b1) kd_seen <= kd_seen + 1;
    if ((|core_reset) || (|core_start)) touch_seen <= touch_seen + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_launch(input logic [7:0] tc);
    launch_valid        = 1'b1;
    launch_thread_count = tc;
    step();
    launch_valid        = 1'b0;
  endtask

  // Serves a single-block kernel on core 0: wait for its reset pulse, complete it, expect kernel_done.
  task automatic serve_one_block(input string tag, input logic [2:0] exp_tc);
    int n = 0;
    while (core_reset === 2'b00 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_reset"}, 32'(core_reset), 32'h1);
    check({tag, "_tc"}, 32'(core_thread_count[0]), 32'(exp_tc));
    check({tag, "_id"}, 32'(core_block_id[0]), 32'h0);
    step();
    check({tag, "_start"}, 32'(core_start), 32'h1);
    core_done = 2'b01;
    step();
    core_done = 2'b00;
    check({tag, "_kdone"}, 32'(kernel_done), 32'h1);
  endtask

  initial begin
    reset               = 1'b1;
    launch_valid        = 1'b0;
    launch_thread_count = '0;
    core_done           = '0;
    step(2);
    check("rst_ready", 32'(launch_ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_qcount", 32'(queue_count), 32'h0);
    check("rst_start", 32'(core_start), 32'h0);
    check("rst_creset", 32'(core_reset), 32'h0);
    check("rst_kdone", 32'(kernel_done), 32'h0);
    check("rst_ids", 32'(core_block_id), 32'h0);
    reset = 1'b0;
    step();

    // 8 threads: two full blocks on cores 0 and 1, completed one at a time.
    push_launch(8'd8);
    check("a_qcount1", 32'(queue_count), 32'h1);
    check("a_busy", 32'(busy), 32'h1);
    step(2);
    check("a_qcount0", 32'(queue_count), 32'h0);
    step();
    check("a_creset0", 32'(core_reset), 32'h1);
    check("a_id0", 32'(core_block_id[0]), 32'h0);
    check("a_tc0", 32'(core_thread_count[0]), 32'h4);
    check("a_start_none", 32'(core_start), 32'h0);
    step();
    check("a_creset1", 32'(core_reset), 32'h2);
    check("a_start0", 32'(core_start), 32'h1);
    check("a_id1", 32'(core_block_id[1]), 32'h1);
    check("a_tc1", 32'(core_thread_count[1]), 32'h4);
    step();
    check("a_start_both", 32'(core_start), 32'h3);
    check("a_creset_clr", 32'(core_reset), 32'h0);
    core_done = 2'b01;
    step();
    check("a_start_c1", 32'(core_start), 32'h2);
    check("a_kdone_early", 32'(kernel_done), 32'h0);
    core_done = 2'b10;
    step();
    core_done = 2'b00;
    check("a_kdone", 32'(kernel_done), 32'h1);
    check("a_start_idle", 32'(core_start), 32'h0);
    step();
    check("a_kdone_pulse", 32'(kernel_done), 32'h0);
    check("a_busy_end", 32'(busy), 32'h0);
    check("a_kd_count", 32'(kd_seen), 32'h1);

    // 10 threads: three blocks, last one carries 2 threads and reuses core 0.
    push_launch(8'd10);
    step(3);
    check("b_creset0", 32'(core_reset), 32'h1);
    check("b_tc0", 32'(core_thread_count[0]), 32'h4);
    step();
    check("b_creset1", 32'(core_reset), 32'h2);
    check("b_id1", 32'(core_block_id[1]), 32'h1);
    core_done = 2'b01;
    step();
    core_done = 2'b00;
    check("b_start_c1", 32'(core_start), 32'h2);
    check("b_no_assign", 32'(core_reset), 32'h0);
    step();
    check("b_reuse_c0", 32'(core_reset), 32'h1);
    check("b_id2", 32'(core_block_id[0]), 32'h2);
    check("b_tc2", 32'(core_thread_count[0]), 32'h2);
    step();
    check("b_start_both", 32'(core_start), 32'h3);
    core_done = 2'b10;
    step();
    check("b_kdone_early", 32'(kernel_done), 32'h0);
    core_done = 2'b01;
    step();
    core_done = 2'b00;
    check("b_kdone", 32'(kernel_done), 32'h1);
    step();
    check("b_kdone_pulse", 32'(kernel_done), 32'h0);
    check("b_kd_count", 32'(kd_seen), 32'h2);

    // Empty kernel: done pulse without touching any core.
    kd0    = kd_seen;
    touch0 = touch_seen;
    push_launch(8'd0);
    step();
    check("c_kdone_load", 32'(kernel_done), 32'h0);
    step();
    check("c_kdone", 32'(kernel_done), 32'h1);
    check("c_busy", 32'(busy), 32'h0);
    step();
    check("c_kdone_pulse", 32'(kernel_done), 32'h0);
    check("c_kd_count", 32'(kd_seen - kd0), 32'h1);
    check("c_no_touch", 32'(touch_seen - touch0), 32'h0);

    // 8 threads with both cores finishing in the same cycle.
    kd0 = kd_seen;
    push_launch(8'd8);
    step(5);
    check("d_start_both", 32'(core_start), 32'h3);
    check("d_kdone_early", 32'(kernel_done), 32'h0);
    core_done = 2'b11;
    step();
    core_done = 2'b00;
    check("d_kdone", 32'(kernel_done), 32'h1);
    check("d_start_idle", 32'(core_start), 32'h0);
    step();
    check("d_kdone_pulse", 32'(kernel_done), 32'h0);
    check("d_kd_count", 32'(kd_seen - kd0), 32'h1);

    // Stalled kernel in DRAIN; five back-to-back pushes fill the queue and drop the fifth.
    kd0 = kd_seen;
    push_launch(8'd4);
    step(4);
    check("e_stall_start", 32'(core_start), 32'h1);
    for (int i = 1; i <= 5; i++) begin
      launch_valid        = 1'b1;
      launch_thread_count = 8'(i);
      step();
      if (i == 3) check("e_ready3", 32'(launch_ready), 32'h1);
      if (i == 4) check("e_ready4", 32'(launch_ready), 32'h0);
    end
    launch_valid = 1'b0;
    check("e_qcount_full", 32'(queue_count), 32'h4);
    check("e_ready_full", 32'(launch_ready), 32'h0);
    check("e_stalled", 32'(kernel_done), 32'h0);
    core_done = 2'b01;
    step();
    core_done = 2'b00;
    check("e_kdone_stall", 32'(kernel_done), 32'h1);
    serve_one_block("e_k1", 3'd1);
    serve_one_block("e_k2", 3'd2);
    serve_one_block("e_k3", 3'd3);
    serve_one_block("e_k4", 3'd4);
    step(8);
    check("e_qcount_drained", 32'(queue_count), 32'h0);
    check("e_busy_end", 32'(busy), 32'h0);
    check("e_kd_count", 32'(kd_seen - kd0), 32'h5);

    // Reset during DISPATCH with two launches queued.
    push_launch(8'd12);
    step(4);
    check("f_start", 32'(core_start), 32'h1);
    push_launch(8'd4);
    push_launch(8'd4);
    check("f_qcount2", 32'(queue_count), 32'h2);
    check("f_start_both", 32'(core_start), 32'h3);
    check("f_busy", 32'(busy), 32'h1);
    kd0 = kd_seen;
    reset = 1'b1;
    #1;
    check("f_async_start", 32'(core_start), 32'h0);
    check("f_async_qcount", 32'(queue_count), 32'h0);
    step(2);
    reset = 1'b0;
    check("f_creset", 32'(core_reset), 32'h0);
    check("f_ids", 32'(core_block_id), 32'h0);
    check("f_tcs", 32'(core_thread_count), 32'h0);
    check("f_ready", 32'(launch_ready), 32'h1);
    step(6);
    check("f_busy_after", 32'(busy), 32'h0);
    check("f_start_after", 32'(core_start), 32'h0);
    check("f_no_kdone", 32'(kd_seen - kd0), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
